// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: maps RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-only data memory.
// Latency: loads, SW and errors respond 1 cycle after accept; SB/SH respond after 2 (read, then merged write).
// Backpressure: req_ready is high only in IDLE (and out of reset); a request not accepted must be held by the core.
//
// Ports: clk/reset (async, active-low); req_* request handshake and fields; resp_* one-cycle
// completion pulse with load data and error flag; mem_* word-indexed memory port (combinational
// read data). Defining LSU_STATS_EN adds stat_loads/stat_stores/stat_errs completion counters.
module lsu_align_unit #(
  parameter int ADDR_W = 6,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [XLEN-1:0]   mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic [XLEN-1:0]    merge_q, merge_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;

  logic               accept;
  logic [ADDR_W-1:0]  idx;
  logic [1:0]         off;
  logic               is_byte, is_half, is_word, req_err;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic               ext_bit;
  logic [XLEN-1:0]    load_ext;
  logic [XLEN-1:0]    merged;

  // Upper address bits are deliberately dropped so addresses wrap within the memory.
  logic unused_addr;
  assign unused_addr = ^req_addr[XLEN-1:ADDR_W+2];

  assign idx       = req_addr[ADDR_W+1:2];
  assign off       = req_addr[1:0];
  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  // funct3[2] selects zero-extension for loads; 011/110/111 are illegal.
  assign is_byte = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
  assign is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  assign is_word = (req_funct3 == 3'b010);
  assign req_err = !(is_byte || is_half || is_word)
                 || (is_half && off[0])
                 || (is_word && (off != 2'b00));

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_bit  = 1'b0;
    load_ext = mem_rdata;
    if (is_byte) begin
      ext_bit  = !req_funct3[2] && byte_sel[7];
      load_ext = {{(XLEN-8){ext_bit}}, byte_sel};
    end else if (is_half) begin
      ext_bit  = !req_funct3[2] && half_sel[15];
      load_ext = {{(XLEN-16){ext_bit}}, half_sel};
    end
  end

  // Word as it should look after a sub-word store: current contents with the lane replaced.
  always_comb begin
    merged = mem_rdata;
    if (is_byte) merged[{off, 3'b000} +: 8]         = req_wdata[7:0];
    else         merged[{off[1], 4'b0000} +: 16]    = req_wdata[15:0];
  end

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    merge_d      = merge_q;
    addr_d       = addr_q;
    we_d         = we_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d         = req_we;
          state_d      = RESP;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (req_err) begin
            resp_err_d = 1'b1;
          end else if (!req_we) begin
            mem_re       = 1'b1;
            mem_addr     = idx;
            resp_rdata_d = load_ext;
          end else if (is_word) begin
            mem_we    = 1'b1;
            mem_addr  = idx;
            mem_wdata = req_wdata;
          end else begin
            mem_re   = 1'b1;
            mem_addr = idx;
            merge_d  = merged;
            addr_d   = idx;
            state_d  = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = merge_q;
        state_d   = RESP;
      end
      RESP: begin
        state_d      = IDLE;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      merge_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef LSU_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  // An erroring store counts only as an error.
  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == RESP) begin
      if (resp_err_q)  stat_errs_d   = stat_errs_q + 32'd1;
      else if (we_q)   stat_stores_d = stat_stores_q + 32'd1;
      else             stat_loads_d  = stat_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_lsu_align_unit.sv
module tb_lsu_align_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  lsu_align_unit #(.ADDR_W(6), .XLEN(32)) dut (
`ifdef LSU_STATS_EN
    .stat_loads(stat_loads),
    .stat_stores(stat_stores),
    .stat_errs(stat_errs),
`endif
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model: combinational read, write on the rising edge.
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        acc_re;
    logic        acc_we;
    int          lat;
    logic        chk;
    logic [5:0]  chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_loads = 0, m_stores = 0, m_errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("v%0d resp_rdata", e.id), resp_rdata, e.rdata);
        chk($sformatf("v%0d resp_err", e.id), {31'd0, resp_err}, {31'd0, e.err});
      end
    end
    if (mem_re && mem_we) chk("re_we exclusive", 32'd1, 32'd0);
    if (!mem_re && !mem_we && (mem_addr != 6'd0 || mem_wdata != 32'd0))
      chk("idle mem bus", {26'd0, mem_addr} | mem_wdata, 32'd0);
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic acc_re, input logic acc_we,
                              input int lat, input logic chk_en, input logic [5:0] chk_idx,
                              input logic [31:0] chk_val);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.acc_re = acc_re; v.acc_we = acc_we; v.lat = lat;
    v.chk = chk_en; v.chk_idx = chk_idx; v.chk_val = chk_val;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.id = id;
    sb_q.push_back(e);
    #1;
    chk($sformatf("v%0d req_ready", id), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d acc mem_re", id), {31'd0, mem_re}, {31'd0, v.acc_re});
    chk($sformatf("v%0d acc mem_we", id), {31'd0, mem_we}, {31'd0, v.acc_we});
    if (v.acc_re || v.acc_we)
      chk($sformatf("v%0d acc mem_addr", id), {26'd0, mem_addr}, {26'd0, v.addr[7:2]});
    if (v.acc_we)
      chk($sformatf("v%0d acc mem_wdata", id), mem_wdata, v.wdata);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.lat == 2) begin
      #1;
      chk($sformatf("v%0d rmw mem_we", id), {31'd0, mem_we}, 32'd1);
      chk($sformatf("v%0d rmw mem_addr", id), {26'd0, mem_addr}, {26'd0, v.chk_idx});
      chk($sformatf("v%0d rmw mem_wdata", id), mem_wdata, v.chk_val);
      chk($sformatf("v%0d rmw early resp", id), {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk($sformatf("v%0d resp latency", id), {31'd0, resp_valid}, 32'd1);
    if (v.chk) chk($sformatf("v%0d mem word", id), mem[v.chk_idx], v.chk_val);
    if (v.exp_err) m_errs++;
    else if (v.we) m_stores++;
    else m_loads++;
  endtask

  vec_t vecs[20];

  initial begin
    //            we   f3      addr      wdata         rdata         err  re  we  lat chk idx  val
    vecs[0]  = mk(1, 3'b010, 32'h0C,  32'h11223344, 32'h0,        0,  0,  1,  1,  1,  3, 32'h11223344);
    vecs[1]  = mk(0, 3'b000, 32'h0F,  32'h0,        32'h00000011, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[2]  = mk(0, 3'b001, 32'h0E,  32'h0,        32'h00001122, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[3]  = mk(1, 3'b010, 32'h0C,  32'h80FF0000, 32'h0,        0,  0,  1,  1,  1,  3, 32'h80FF0000);
    vecs[4]  = mk(0, 3'b101, 32'h0E,  32'h0,        32'h000080FF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[5]  = mk(0, 3'b001, 32'h0E,  32'h0,        32'hFFFF80FF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[6]  = mk(0, 3'b000, 32'h0E,  32'h0,        32'hFFFFFFFF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[7]  = mk(0, 3'b100, 32'h0E,  32'h0,        32'h000000FF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[8]  = mk(0, 3'b101, 32'h0C,  32'h0,        32'h00000000, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[9]  = mk(1, 3'b010, 32'h08,  32'hDEADBEEF, 32'h0,        0,  0,  1,  1,  1,  2, 32'hDEADBEEF);
    vecs[10] = mk(1, 3'b000, 32'h09,  32'hAAAAAA55, 32'h0,        0,  1,  0,  2,  1,  2, 32'hDEAD55EF);
    vecs[11] = mk(1, 3'b001, 32'h0A,  32'hABCD1234, 32'h0,        0,  1,  0,  2,  1,  2, 32'h123455EF);
    vecs[12] = mk(0, 3'b010, 32'h08,  32'h0,        32'h123455EF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[13] = mk(0, 3'b010, 32'h06,  32'h0,        32'h0,        1,  0,  0,  1,  0,  0, 32'h0);
    vecs[14] = mk(1, 3'b001, 32'h03,  32'h1234,     32'h0,        1,  0,  0,  1,  0,  0, 32'h0);
    vecs[15] = mk(0, 3'b011, 32'h08,  32'h0,        32'h0,        1,  0,  0,  1,  0,  0, 32'h0);
    vecs[16] = mk(0, 3'b010, 32'h108, 32'h0,        32'h123455EF, 0,  1,  0,  1,  0,  0, 32'h0);
    vecs[17] = mk(1, 3'b000, 32'h0B,  32'h00000099, 32'h0,        0,  1,  0,  2,  1,  2, 32'h993455EF);
    vecs[18] = mk(1, 3'b010, 32'h04,  32'hCAFEF00D, 32'h0,        0,  0,  1,  1,  1,  1, 32'hCAFEF00D);
    vecs[19] = mk(1, 3'b110, 32'h04,  32'h0,        32'h0,        1,  0,  0,  1,  0,  0, 32'h0);

    // Reset with a request already presented: nothing may leak to memory.
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0C; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post rst req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

`ifdef LSU_STATS_EN
    chk("stat_loads", stat_loads, m_loads);
    chk("stat_stores", stat_stores, m_stores);
    chk("stat_errs", stat_errs, m_errs);
`endif

    // Reset during RMW_WR of SB 0x04: the merged write must never happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h04; req_wdata = 32'h00000077;
    #1;
    chk("rmwrst acc mem_re", {31'd0, mem_re}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rmwrst in RMW_WR", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rmwrst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rmwrst mem_re", {31'd0, mem_re}, 32'd0);
    chk("rmwrst mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("rmwrst mem_wdata", mem_wdata, 32'd0);
    chk("rmwrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rmwrst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rmwrst resp_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmwrst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rmwrst mem[1] kept", mem[1], 32'hCAFEF00D);
`ifdef LSU_STATS_EN
    chk("rmwrst stat_loads", stat_loads, 32'd0);
    chk("rmwrst stat_stores", stat_stores, 32'd0);
    chk("rmwrst stat_errs", stat_errs, 32'd0);
`endif
    m_loads = 0; m_stores = 0; m_errs = 0;
    repeat (3) @(negedge clk);
    run_vec(mk(0, 3'b010, 32'h04, 32'h0, 32'hCAFEF00D, 0, 1, 0, 1, 0, 0, 32'h0), 20);
    run_vec(mk(0, 3'b100, 32'h07, 32'h0, 32'h000000CA, 0, 1, 0, 1, 0, 0, 32'h0), 21);
`ifdef LSU_STATS_EN
    chk("final stat_loads", stat_loads, m_loads);
`endif

    @(negedge clk);
    chk("scoreboard drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the run always terminates even if the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
